// File: rtl/fi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fi_mem_pkg
// Description : Shared types and constants for the fi_mem_responder slice:
//               the responder state enum, the stall LFSR geometry and seed,
//               and the set of legal STALL_MAX values.
// Revision    : 1.0 - initial release
// ============================================================================
package fi_mem_pkg;

   // Responder handshake states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      GRANT = 2'd2
   } fi_state_e;

   // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1. With a left shift the
   // taps sit at bit positions 15, 13, 12 and 10.
   localparam int          c_lfsr_width = 16;
   localparam logic [15:0] c_lfsr_taps  = 16'hB400;
   localparam logic [15:0] c_lfsr_seed  = 16'hACE1;

   // Bit v set means STALL_MAX == v is legal (0, 1, 3, 7, 15). These are the
   // all-ones masks, so "lfsr & STALL_MAX" spans 0..STALL_MAX uniformly.
   localparam logic [15:0] c_stall_legal = 16'h808B;

   function automatic logic stall_max_legal(input int unsigned v);
      logic [3:0] idx;
      idx = v[3:0];
      return (v < 32'd16) && c_stall_legal[idx];
   endfunction

endpackage : fi_mem_pkg
`default_nettype wire

// File: rtl/fi_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : fi_lfsr16
// Description : 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that advances
//               every clock. Used as the random wait-state source of
//               fi_mem_responder when FI_MEM_RAND_STALL_EN is defined.
// Ports       : clock - clock
//               reset - synchronous active-high reset, loads SEED
//               lfsr  - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module fi_lfsr16
   import fi_mem_pkg::*;
#(
   parameter logic [c_lfsr_width-1:0] SEED = c_lfsr_seed
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic [c_lfsr_width-1:0] lfsr
);

   logic [c_lfsr_width-1:0] lfsr_q;
   logic [c_lfsr_width-1:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[c_lfsr_width-2:0], ^(lfsr_q & c_lfsr_taps)};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr = lfsr_q;

endmodule : fi_lfsr16
`default_nettype wire

// File: rtl/fi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : fi_mem_responder
// Description : Memory-side responder for a req/gnt memory port. Holds a
//               word-addressed backing store, inserts wait states and flags
//               misaligned or out-of-range accesses with mem_error.
// Config      : FI_MEM_RAND_STALL_EN - when defined, wait states per request
//               are lfsr[3:0] & STALL_MAX from a free-running LFSR; when
//               undefined every request waits exactly STALL_MAX cycles.
// Ports       : clock, reset          - clock, synchronous active-high reset
//               mem_req/wen/strb/wdata/addr - request from the initiator
//               mem_gnt               - transaction completes this cycle
//               mem_error, mem_rdata  - response, valid with mem_gnt
//               txn_count             - granted transactions, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module fi_mem_responder
   import fi_mem_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE      = 32'h0000_0000,
   parameter int unsigned STALL_MAX = 1,
   parameter logic [15:0] LFSR_SEED = c_lfsr_seed
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_req,
   input  logic        mem_wen,
   input  logic [3:0]  mem_strb,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic        mem_gnt,
   output logic        mem_error,
   output logic [31:0] mem_rdata,
   output logic [31:0] txn_count
);

   localparam int unsigned c_idx_w     = $clog2(DEPTH);
   localparam logic [3:0]  c_stall_max = STALL_MAX[3:0];

   if (!stall_max_legal(STALL_MAX)) begin : g_bad_stall_max
      $error("fi_mem_responder: STALL_MAX must be 0, 1, 3, 7 or 15");
   end

   // ------------------------------------------------------------------------
   // Wait-state source
   // ------------------------------------------------------------------------
   logic [3:0] w_stall;

`ifdef FI_MEM_RAND_STALL_EN
   logic [c_lfsr_width-1:0] w_lfsr;
   logic [c_lfsr_width-5:0] w_unused_lfsr_hi;

   fi_lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clock (clock),
      .reset (reset),
      .lfsr  (w_lfsr)
   );

   assign w_stall          = w_lfsr[3:0] & c_stall_max;
   assign w_unused_lfsr_hi = w_lfsr[c_lfsr_width-1:4];
`else
   localparam logic [15:0] c_unused_seed = LFSR_SEED;

   assign w_stall = c_stall_max;
`endif

   // ------------------------------------------------------------------------
   // Address decode. BASE is aligned to the store size, so the range check
   // reduces to comparing the bits above the word index.
   // ------------------------------------------------------------------------
   logic [31:0]        mem_q [DEPTH];
   logic [c_idx_w-1:0] w_idx;
   logic               w_fault;

   assign w_idx   = mem_addr[c_idx_w+1:2];
   assign w_fault = (mem_addr[1:0] != 2'b00) ||
                    (mem_addr[31:c_idx_w+2] != BASE[31:c_idx_w+2]);

   // ------------------------------------------------------------------------
   // Handshake FSM and response registers
   // ------------------------------------------------------------------------
   fi_state_e   state_q, state_d;
   logic [3:0]  stall_q, stall_d;
   logic        error_q, error_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] count_q, count_d;
   logic        w_enter_grant;

   always_comb begin
      state_d = state_q;
      stall_d = stall_q;

      case (state_q)
         IDLE: begin
            if (mem_req) begin
               stall_d = w_stall;
               state_d = (w_stall == 4'd0) ? GRANT : WAIT;
            end
         end
         WAIT: begin
            // A dropped request is abandoned; nothing is written.
            if (!mem_req) begin
               state_d = IDLE;
            end else begin
               stall_d = stall_q - 4'd1;
               if (stall_q == 4'd1) begin
                  state_d = GRANT;
               end
            end
         end
         GRANT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The response is captured on the edge that enters GRANT, so it is
      // sampled before any write of the same transaction commits. The
      // counter also steps on that edge, so txn_count already includes the
      // transaction being granted while mem_gnt is high.
      w_enter_grant = (state_d == GRANT);
      error_d       = w_enter_grant && w_fault;
      rdata_d       = (w_enter_grant && !w_fault) ? mem_q[w_idx] : 32'd0;
      count_d       = w_enter_grant ? (count_q + 32'd1) : count_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         stall_q <= 4'd0;
         error_q <= 1'b0;
         rdata_q <= 32'd0;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         error_q <= error_d;
         rdata_q <= rdata_d;
         count_q <= count_d;
      end
   end

   // ------------------------------------------------------------------------
   // Backing store write. Not reset; a write still pending in GRANT when
   // reset is asserted is dropped.
   // ------------------------------------------------------------------------
   logic w_commit;

   assign w_commit = !reset && (state_q == GRANT) && mem_wen && !error_q;

   always_ff @(posedge clock) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_strb[i]) begin
               mem_q[w_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   assign mem_gnt   = (state_q == GRANT);
   assign mem_error = error_q;
   assign mem_rdata = rdata_q;
   assign txn_count = count_q;

endmodule : fi_mem_responder
`default_nettype wire

// File: tb/tb_fi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fi_mem_responder
// Description : Directed self-checking bench for fi_mem_responder. Four
//               instances with STALL_MAX 0, 1, 3 and 7 share clock and reset
//               and have independent request ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fi_mem_responder;

   localparam int D_S0 = 0;
   localparam int D_S1 = 1;
   localparam int D_S3 = 2;
   localparam int D_S7 = 3;

   logic clk = 1'b0;
   logic rst;

   logic        req   [4];
   logic        wen   [4];
   logic [3:0]  strb  [4];
   logic [31:0] wdata [4];
   logic [31:0] addr  [4];
   logic        gnt   [4];
   logic        err   [4];
   logic [31:0] rdata [4];
   logic [31:0] cnt   [4];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fi_mem_responder #(.STALL_MAX(0)) dut_s0 (
      .clock(clk), .reset(rst), .mem_req(req[D_S0]), .mem_wen(wen[D_S0]),
      .mem_strb(strb[D_S0]), .mem_wdata(wdata[D_S0]), .mem_addr(addr[D_S0]),
      .mem_gnt(gnt[D_S0]), .mem_error(err[D_S0]), .mem_rdata(rdata[D_S0]),
      .txn_count(cnt[D_S0])
   );

   fi_mem_responder #(.STALL_MAX(1)) dut_s1 (
      .clock(clk), .reset(rst), .mem_req(req[D_S1]), .mem_wen(wen[D_S1]),
      .mem_strb(strb[D_S1]), .mem_wdata(wdata[D_S1]), .mem_addr(addr[D_S1]),
      .mem_gnt(gnt[D_S1]), .mem_error(err[D_S1]), .mem_rdata(rdata[D_S1]),
      .txn_count(cnt[D_S1])
   );

   fi_mem_responder #(.STALL_MAX(3)) dut_s3 (
      .clock(clk), .reset(rst), .mem_req(req[D_S3]), .mem_wen(wen[D_S3]),
      .mem_strb(strb[D_S3]), .mem_wdata(wdata[D_S3]), .mem_addr(addr[D_S3]),
      .mem_gnt(gnt[D_S3]), .mem_error(err[D_S3]), .mem_rdata(rdata[D_S3]),
      .txn_count(cnt[D_S3])
   );

   fi_mem_responder #(.STALL_MAX(7)) dut_s7 (
      .clock(clk), .reset(rst), .mem_req(req[D_S7]), .mem_wen(wen[D_S7]),
      .mem_strb(strb[D_S7]), .mem_wdata(wdata[D_S7]), .mem_addr(addr[D_S7]),
      .mem_gnt(gnt[D_S7]), .mem_error(err[D_S7]), .mem_rdata(rdata[D_S7]),
      .txn_count(cnt[D_S7])
   );

   // One complete transaction on instance d. Entered and left just after a
   // rising edge. lat counts rising edges from request to grant.
   task automatic txn(input int d, input logic w, input logic [3:0] s,
                      input logic [31:0] wd, input logic [31:0] a,
                      output logic [31:0] rd, output logic er,
                      output logic [31:0] c, output int lat, output bit ok);
      wen[d]   = w;
      strb[d]  = s;
      wdata[d] = wd;
      addr[d]  = a;
      req[d]   = 1'b1;
      ok  = 1'b0;
      lat = 0;
      rd  = 32'd0;
      er  = 1'b0;
      c   = 32'd0;
      while (!ok && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (gnt[d] === 1'b1) begin
            ok = 1'b1;
            rd = rdata[d];
            er = err[d];
            c  = cnt[d];
         end
      end
      @(posedge clk);
      #1;
      req[d] = 1'b0;
      wen[d] = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd, c;
      logic        er;
      int          lat;
      bit          ok;
      // Preload through the port, then reset again: the store must survive.
      txn(D_S1, 1'b1, 4'hF, 32'h0000_0000, 32'h10, rd, er, c, lat, ok);
      txn(D_S1, 1'b1, 4'hF, 32'h1122_3344, 32'h20, rd, er, c, lat, ok);
      txn(D_S1, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h00, rd, er, c, lat, ok);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (gnt[D_S1] !== 1'b0) $display("FAIL reset_gnt: got %b expected 0", gnt[D_S1]); else n_pass++;
      n_total++;
      if (err[D_S1] !== 1'b0) $display("FAIL reset_error: got %b expected 0", err[D_S1]); else n_pass++;
      n_total++;
      if (rdata[D_S1] !== 32'd0) $display("FAIL reset_rdata: got %h expected 00000000", rdata[D_S1]); else n_pass++;
      n_total++;
      if (cnt[D_S1] !== 32'd0) $display("FAIL reset_count: got %0d expected 0", cnt[D_S1]); else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;

      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'h10, rd, er, c, lat, ok);
      n_total++;
      if (ok !== 1'b1) $display("FAIL reset_read_timeout: got no grant expected grant"); else n_pass++;
`ifndef FI_MEM_RAND_STALL_EN
      n_total++;
      if (lat != 2) $display("FAIL reset_read_latency: got %0d expected 2", lat); else n_pass++;
`endif
      n_total++;
      if (rd !== 32'd0) $display("FAIL reset_read_rdata: got %h expected 00000000", rd); else n_pass++;
      n_total++;
      if (er !== 1'b0) $display("FAIL reset_read_error: got %b expected 0", er); else n_pass++;
      n_total++;
      if (c !== 32'd1) $display("FAIL reset_read_count: got %0d expected 1", c); else n_pass++;
   endtask

   task automatic test_strobed_write();
      logic [31:0] rd, c;
      logic        er;
      int          lat;
      bit          ok;
      txn(D_S1, 1'b1, 4'b0101, 32'hDEAD_BEEF, 32'h20, rd, er, c, lat, ok);
      n_total++;
      if (ok !== 1'b1 || er !== 1'b0) $display("FAIL strb_write_status: got ok=%b err=%b expected ok=1 err=0", ok, er); else n_pass++;
      n_total++;
      if (rd !== 32'h1122_3344) $display("FAIL strb_write_old_data: got %h expected 11223344", rd); else n_pass++;
      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'h20, rd, er, c, lat, ok);
      n_total++;
      if (rd !== 32'h11AD_33EF) $display("FAIL strb_readback: got %h expected 11ad33ef", rd); else n_pass++;
      txn(D_S1, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h20, rd, er, c, lat, ok);
      n_total++;
      if (er !== 1'b0) $display("FAIL strb_zero_error: got %b expected 0", er); else n_pass++;
      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'h20, rd, er, c, lat, ok);
      n_total++;
      if (rd !== 32'h11AD_33EF) $display("FAIL strb_zero_readback: got %h expected 11ad33ef", rd); else n_pass++;
   endtask

   task automatic test_faults();
      logic [31:0] rd, c, c0;
      logic        er;
      int          lat;
      bit          ok;
      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'h10, rd, er, c0, lat, ok);
      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'h22, rd, er, c, lat, ok);
      n_total++;
      if (er !== 1'b1) $display("FAIL fault_misaligned_error: got %b expected 1", er); else n_pass++;
      n_total++;
      if (rd !== 32'd0) $display("FAIL fault_misaligned_rdata: got %h expected 00000000", rd); else n_pass++;
      n_total++;
      if (c !== c0 + 32'd1) $display("FAIL fault_counted: got %0d expected %0d", c, c0 + 32'd1); else n_pass++;
      txn(D_S1, 1'b1, 4'hF, 32'h1234_5678, 32'h1000, rd, er, c, lat, ok);
      n_total++;
      if (er !== 1'b1) $display("FAIL fault_range_error: got %b expected 1", er); else n_pass++;
      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'h0, rd, er, c, lat, ok);
      n_total++;
      if (rd !== 32'hCAFE_F00D || er !== 1'b0) $display("FAIL fault_word0_intact: got %h err=%b expected cafef00d err=0", rd, er); else n_pass++;
      txn(D_S1, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h21, rd, er, c, lat, ok);
      n_total++;
      if (er !== 1'b1) $display("FAIL fault_misaligned_write_error: got %b expected 1", er); else n_pass++;
      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'h20, rd, er, c, lat, ok);
      n_total++;
      if (rd !== 32'h11AD_33EF) $display("FAIL fault_misaligned_no_write: got %h expected 11ad33ef", rd); else n_pass++;
      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'hFFC, rd, er, c, lat, ok);
      n_total++;
      if (er !== 1'b0) $display("FAIL fault_last_word_error: got %b expected 0", er); else n_pass++;
      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'hFFFF_FFFC, rd, er, c, lat, ok);
      n_total++;
      if (er !== 1'b1) $display("FAIL fault_high_addr_error: got %b expected 1", er); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic exp_gnt;
      wen[D_S0]  = 1'b0;
      strb[D_S0] = 4'h0;
      addr[D_S0] = 32'h10;
      req[D_S0]  = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         exp_gnt = (k % 2 == 1);
         n_total++;
         if (gnt[D_S0] !== exp_gnt) $display("FAIL b2b_gnt_cycle%0d: got %b expected %b", k, gnt[D_S0], exp_gnt); else n_pass++;
      end
      req[D_S0] = 1'b0;
      n_total++;
      if (cnt[D_S0] !== 32'd3) $display("FAIL b2b_count: got %0d expected 3", cnt[D_S0]); else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_abandon();
`ifndef FI_MEM_RAND_STALL_EN
      logic [31:0] rd, c, c0;
      logic        er;
      int          lat;
      bit          ok;
      txn(D_S3, 1'b1, 4'hF, 32'hA5A5_A5A5, 32'h40, rd, er, c0, lat, ok);
      n_total++;
      if (lat != 4) $display("FAIL abandon_setup_latency: got %0d expected 4", lat); else n_pass++;
      wen[D_S3]   = 1'b1;
      strb[D_S3]  = 4'hF;
      wdata[D_S3] = 32'h5A5A_5A5A;
      addr[D_S3]  = 32'h40;
      req[D_S3]   = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         n_total++;
         if (gnt[D_S3] !== 1'b0) $display("FAIL abandon_gnt_cycle%0d: got %b expected 0", k, gnt[D_S3]); else n_pass++;
         if (k == 2) begin
            req[D_S3] = 1'b0;
            wen[D_S3] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      txn(D_S3, 1'b0, 4'h0, 32'd0, 32'h40, rd, er, c, lat, ok);
      n_total++;
      if (rd !== 32'hA5A5_A5A5) $display("FAIL abandon_no_write: got %h expected a5a5a5a5", rd); else n_pass++;
      n_total++;
      if (c !== c0 + 32'd1) $display("FAIL abandon_not_counted: got %0d expected %0d", c, c0 + 32'd1); else n_pass++;
`endif
   endtask

   task automatic test_reset_in_grant();
      logic [31:0] rd, c;
      logic        er;
      int          lat;
      bit          ok, got;
      txn(D_S1, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h50, rd, er, c, lat, ok);
      wen[D_S1]   = 1'b1;
      strb[D_S1]  = 4'hF;
      wdata[D_S1] = 32'h1357_9BDF;
      addr[D_S1]  = 32'h50;
      req[D_S1]   = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (gnt[D_S1] === 1'b1) got = 1'b1;
      end
      n_total++;
      if (got !== 1'b1) $display("FAIL rst_grant_timeout: got no grant expected grant"); else n_pass++;
      rst       = 1'b1;
      req[D_S1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (gnt[D_S1] !== 1'b0) $display("FAIL rst_grant_gnt: got %b expected 0", gnt[D_S1]); else n_pass++;
      n_total++;
      if (cnt[D_S1] !== 32'd0) $display("FAIL rst_grant_count: got %0d expected 0", cnt[D_S1]); else n_pass++;
      rst       = 1'b0;
      wen[D_S1] = 1'b0;
      @(posedge clk);
      #1;
      txn(D_S1, 1'b0, 4'h0, 32'd0, 32'h50, rd, er, c, lat, ok);
      n_total++;
      if (rd !== 32'h0BAD_F00D) $display("FAIL rst_grant_write_dropped: got %h expected 0badf00d", rd); else n_pass++;
   endtask

   task automatic test_stall_max7();
      logic [31:0] rd, c;
      logic        er;
      int          lat;
      bit          ok;
`ifdef FI_MEM_RAND_STALL_EN
      bit seen [9];
      for (int v = 0; v < 9; v++) seen[v] = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         txn(D_S7, 1'b0, 4'h0, 32'd0, (i * 4) & 32'hFFC, rd, er, c, lat, ok);
         n_total++;
         if (!ok || lat < 1 || lat > 8) $display("FAIL rand_latency_req%0d: got %0d expected 1..8", i, lat); else begin
            n_pass++;
            seen[lat] = 1'b1;
         end
      end
      for (int v = 1; v <= 8; v++) begin
         n_total++;
         if (seen[v] !== 1'b1) $display("FAIL rand_cover_lat%0d: got unseen expected seen", v); else n_pass++;
      end
`else
      for (int i = 0; i < 4; i++) begin
         txn(D_S7, 1'b0, 4'h0, 32'd0, 32'h100 + i * 4, rd, er, c, lat, ok);
         n_total++;
         if (lat != 8) $display("FAIL fixed_latency_req%0d: got %0d expected 8", i, lat); else n_pass++;
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 4; d++) begin
         req[d]   = 1'b0;
         wen[d]   = 1'b0;
         strb[d]  = 4'h0;
         wdata[d] = 32'd0;
         addr[d]  = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      test_reset();
      test_strobed_write();
      test_faults();
      test_back_to_back();
      test_abandon();
      test_reset_in_grant();
      test_stall_max7();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule : tb_fi_mem_responder
`default_nettype wire
